io_bus_master: RTL and testbench

//   Bus-master side of the shared tristate I/O data bus used by the Port registers.
//   - Accepts single read/write commands from the CPU core over a valid/ready handshake.
//   - Drives the one-hot per-port read/write strobes, drives or releases data_bus, and returns read data.
//   - Guarantees one idle turnaround cycle (or more) after every read, so master and port never drive together.

---
 rtl/io_bus_pkg.sv | 22 ++
 rtl/io_port_decode.sv | 23 ++
 rtl/io_bus_master.sv | 125 ++++++++++++
 tb/tb_io_bus_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and defaults for the I/O bus master and its decode helper.
package io_bus_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 2;

    // Bus master sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        TURN = 2'd3
    } bus_state_e;

    // One CPU command at the default widths.
    typedef struct packed {
        logic                      write;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } io_cmd_t;

endpackage

// File: rtl/io_port_decode.sv
// Port address decoder: one-hot select plus a flag for addresses with no port behind them.
module io_port_decode
    import io_bus_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [NPORTS-1:0] onehot,
    output logic              out_of_range
);

    assign out_of_range = (32'(addr) >= 32'(NPORTS));

    // An out-of-range address matches no bit, so the vector stays all-zero.
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_sel
            assign onehot[gi] = en && (32'(addr) == gi);
        end
    endgenerate

endmodule

// File: rtl/io_bus_master.sv
// Bus master for the shared tristate port bus: one command at a time,
// one-hot strobes, and a guaranteed idle gap after every read.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int NPORTS     = 4,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic [NPORTS-1:0] port_read,
    output logic [NPORTS-1:0] port_write
);

    localparam int CNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    bus_state_e        state_reg, state_next;
    cmd_t              cmd_reg, cmd_next;
    logic [CNT_W-1:0]  turn_cnt_reg, turn_cnt_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic              rsp_err_reg, rsp_err_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic              access_en;
    logic [NPORTS-1:0] sel_onehot;
    logic              addr_oor;
    logic              bus_drive;

    // Strobes and drive enable depend only on registered state/command;
    // the raw reset input additionally silences everything while held.
    assign access_en = reset && ((state_reg == WR) || (state_reg == RD));

    io_port_decode #(
        .NPORTS (NPORTS),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr         (cmd_reg.addr),
        .en           (access_en),
        .onehot       (sel_onehot),
        .out_of_range (addr_oor)
    );

    assign port_write = sel_onehot & {NPORTS{state_reg == WR}};
    assign port_read  = sel_onehot & {NPORTS{state_reg == RD}};
    assign bus_drive  = reset && (state_reg == WR) && !addr_oor;
    assign data_bus   = bus_drive ? cmd_reg.wdata : {DATA_W{1'bz}};

    assign req_ready  = reset && (state_reg == IDLE);
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_rdata  = rsp_rdata_reg;

    // Next-state, command latch, turnaround count and response capture.
    always_comb begin
        state_next     = state_reg;
        cmd_next       = cmd_reg;
        turn_cnt_next  = turn_cnt_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = rsp_err_reg;
        rsp_rdata_next = rsp_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cmd_next.write = req_write;
                    cmd_next.addr  = req_addr;
                    cmd_next.wdata = req_wdata;
                    state_next     = req_write ? WR : RD;
                end
            end
            WR, RD: begin
                // Single access cycle; a read samples the bus at its closing edge.
                rsp_valid_next = 1'b1;
                rsp_err_next   = addr_oor;
                rsp_rdata_next = (cmd_reg.write || addr_oor) ? '0 : data_bus;
                turn_cnt_next  = '0;
                state_next     = cmd_reg.write ? IDLE : TURN;
            end
            TURN: begin
                if (turn_cnt_reg == CNT_W'(TURNAROUND - 1)) begin
                    state_next = IDLE;
                end else begin
                    turn_cnt_next = turn_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and response registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cmd_reg       <= '0;
            turn_cnt_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            turn_cnt_reg  <= turn_cnt_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench: default master (A), NPORTS=3 master (B), TURNAROUND=3 master (C).
module tb_io_bus_master;
    import io_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cont_bad = 0;
    int   cyc = 0;
    int   a_rsp_count = 0;

    always #5 clk = ~clk;

    // ---------------- DUT A: defaults ----------------
    logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_req_ready;
    logic [1:0]  a_req_addr = '0;
    logic [15:0] a_req_wdata = '0, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err;
    logic [3:0]  a_port_read, a_port_write;
    wire  [15:0] a_bus;
    logic [15:0] p0_reg = '0, p1_reg = '0;

    io_bus_master dut_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
        .data_bus(a_bus), .port_read(a_port_read), .port_write(a_port_write)
    );

    // Port 0 and port 1 register models on bus A.
    assign a_bus = a_port_read[0] ? p0_reg : 16'hzzzz;
    assign a_bus = a_port_read[1] ? p1_reg : 16'hzzzz;
    always @(posedge clk) begin
        if (a_port_write[0]) p0_reg <= a_bus;
        if (a_port_write[1]) p1_reg <= a_bus;
    end

    // ---------------- DUT B: three ports ----------------
    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_ready;
    logic [1:0]  b_req_addr = '0;
    logic [15:0] b_req_wdata = '0, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err;
    logic [2:0]  b_port_read, b_port_write;
    wire  [15:0] b_bus;

    io_bus_master #(.NPORTS(3)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .data_bus(b_bus), .port_read(b_port_read), .port_write(b_port_write)
    );
    assign b_bus = b_port_read[0] ? 16'hC3C3 : 16'hzzzz;

    // ---------------- DUT C: TURNAROUND=3 ----------------
    logic        c_req_valid = 1'b0, c_req_write = 1'b0, c_req_ready;
    logic [1:0]  c_req_addr = '0;
    logic [15:0] c_req_wdata = '0, c_rsp_rdata;
    logic        c_rsp_valid, c_rsp_err;
    logic [3:0]  c_port_read, c_port_write;
    wire  [15:0] c_bus;

    io_bus_master #(.TURNAROUND(3)) dut_c (
        .clk(clk), .reset(reset), .req_valid(c_req_valid), .req_ready(c_req_ready),
        .req_write(c_req_write), .req_addr(c_req_addr), .req_wdata(c_req_wdata),
        .rsp_valid(c_rsp_valid), .rsp_err(c_rsp_err), .rsp_rdata(c_rsp_rdata),
        .data_bus(c_bus), .port_read(c_port_read), .port_write(c_port_write)
    );
    assign c_bus = c_port_read[1] ? 16'hBEEF : 16'hzzzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_rsp_valid) a_rsp_count <= a_rsp_count + 1;
    end

    // Contention checker on all three masters, every cycle.
    always @(negedge clk) begin
        assert (!(dut_a.bus_drive && |a_port_read) && $onehot0(a_port_read | a_port_write)
                && !(|a_port_read && |a_port_write))
        else begin
            cont_bad <= cont_bad + 1;
            $display("FAIL contention_a: t=%0t drive=%b rd=%b wr=%b required no overlap",
                     $time, dut_a.bus_drive, a_port_read, a_port_write);
        end
        assert (!(dut_b.bus_drive && |b_port_read) && $onehot0(b_port_read | b_port_write)
                && !(|b_port_read && |b_port_write))
        else begin
            cont_bad <= cont_bad + 1;
            $display("FAIL contention_b: t=%0t drive=%b rd=%b wr=%b required no overlap",
                     $time, dut_b.bus_drive, b_port_read, b_port_write);
        end
        assert (!(dut_c.bus_drive && |c_port_read) && $onehot0(c_port_read | c_port_write)
                && !(|c_port_read && |c_port_write))
        else begin
            cont_bad <= cont_bad + 1;
            $display("FAIL contention_c: t=%0t drive=%b rd=%b wr=%b required no overlap",
                     $time, dut_c.bus_drive, c_port_read, c_port_write);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step();
        step();
        mid();
        total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", a_req_ready); end
        total++; if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 16'h0000) begin
            bad++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0/0/0000", a_rsp_valid, a_rsp_err, a_rsp_rdata); end
        step();
        reset = 1'b1;
        mid();
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", a_req_ready); end
        // Reset in the middle of a write.
        step();
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 2'd0; a_req_wdata = 16'h00A5;
        step();
        a_req_valid = 1'b0;
        reset = 1'b0;
        mid();
        total++; if (a_port_write !== 4'b0000 || a_port_read !== 4'b0000 || dut_a.bus_drive !== 1'b0) begin
            bad++; $display("FAIL midrst_strobe: got wr=%b rd=%b drv=%b want 0000/0000/0", a_port_write, a_port_read, dut_a.bus_drive); end
        step();
        mid();
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_held: got v=%b rdy=%b want 0/0", a_rsp_valid, a_req_ready); end
        step();
        reset = 1'b1;
        mid();
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_release: got rdy=%b v=%b want 1/0", a_req_ready, a_rsp_valid); end
        total++; if (p0_reg !== 16'h0000) begin bad++; $display("FAIL midrst_port0: got %h want 0000", p0_reg); end
        step();
        mid();
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_norsp: got %b want 0", a_rsp_valid); end
        $display("reset: abandoned write, master idle");
    endtask

    task automatic test_write_read();
        step();
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 2'd0; a_req_wdata = 16'h00A5;
        mid();
        total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", a_req_ready); end
        step();
        a_req_valid = 1'b0;
        mid();
        total++; if (a_port_write !== 4'b0001 || a_port_read !== 4'b0000) begin
            bad++; $display("FAIL wr_strobe: got wr=%b rd=%b want 0001/0000", a_port_write, a_port_read); end
        total++; if (a_bus !== 16'h00A5 || dut_a.bus_drive !== 1'b1) begin
            bad++; $display("FAIL wr_bus: got %h drv=%b want 00a5/1", a_bus, dut_a.bus_drive); end
        total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_early_rsp: got %b want 0", a_rsp_valid); end
        step();
        mid();
        total++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0 || a_rsp_rdata !== 16'h0000 || a_port_write !== 4'b0000) begin
            bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h wr=%b want 1/0/0000/0000", a_rsp_valid, a_rsp_err, a_rsp_rdata, a_port_write); end
        total++; if (p0_reg !== 16'h00A5) begin bad++; $display("FAIL wr_port0: got %h want 00a5", p0_reg); end
        $display("write addr0 data=%h rsp_valid=%b", 16'h00A5, a_rsp_valid);
        step();
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 2'd0;
        step();
        a_req_valid = 1'b0;
        mid();
        total++; if (a_port_read !== 4'b0001 || a_port_write !== 4'b0000 || dut_a.bus_drive !== 1'b0) begin
            bad++; $display("FAIL rd_strobe: got rd=%b wr=%b drv=%b want 0001/0000/0", a_port_read, a_port_write, dut_a.bus_drive); end
        total++; if (a_bus !== 16'h00A5) begin bad++; $display("FAIL rd_bus: got %h want 00a5", a_bus); end
        step();
        mid();
        total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h00A5 || a_rsp_err !== 1'b0) begin
            bad++; $display("FAIL rd_rsp: got v=%b d=%h e=%b want 1/00a5/0", a_rsp_valid, a_rsp_rdata, a_rsp_err); end
        total++; if (a_req_ready !== 1'b0 || a_port_read !== 4'b0000) begin
            bad++; $display("FAIL rd_turn: got rdy=%b rd=%b want 0/0000", a_req_ready, a_port_read); end
        step();
        mid();
        total++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'h00A5) begin
            bad++; $display("FAIL rd_hold: got rdy=%b v=%b d=%h want 1/0/00a5", a_req_ready, a_rsp_valid, a_rsp_rdata); end
        $display("read addr0 rdata=%h err=%b", a_rsp_rdata, a_rsp_err);
    endtask

    task automatic test_back_to_back();
        logic [15:0] wd [4];
        int acc [4];
        int rsp_base;
        bit rd_seen [8];
        bit wr_seen [8];
        bit drv_seen [8];
        int phase;
        int r_idx, d_idx;
        bit gap_ok;
        io_cmd_t wcmd;
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        rsp_base = a_rsp_count;
        step();
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 2'd1;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = 0;
            a_req_wdata = wd[i];
            mid();
            while (!a_req_ready && w < 8) begin
                w++;
                mid();
            end
            acc[i] = cyc;
            total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_timeout: write %0d not accepted within 8 cycles", i); end
            step();
            $display("b2b write addr1 data=%h accepted cycle=%0d", wd[i], acc[i]);
        end
        a_req_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            total++; if (acc[i] - acc[i-1] !== 2) begin
                bad++; $display("FAIL b2b_spacing: write %0d spacing got %0d want 2", i, acc[i] - acc[i-1]); end
        end
        step();
        step();
        mid();
        total++; if (p1_reg !== 16'h4444) begin bad++; $display("FAIL b2b_port1: got %h want 4444", p1_reg); end
        total++; if (a_rsp_count - rsp_base !== 4) begin bad++; $display("FAIL b2b_rsp_count: got %0d want 4", a_rsp_count - rsp_base); end

        // Read of port 1 immediately followed by a write to port 0.
        wcmd = '{write: 1'b1, addr: 2'd0, wdata: 16'h5A5A};
        step();
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 2'd1;
        phase = 0;
        for (int k = 0; k < 8; k++) begin
            bit take;
            mid();
            rd_seen[k]  = |a_port_read;
            wr_seen[k]  = |a_port_write;
            drv_seen[k] = dut_a.bus_drive;
            if (a_rsp_valid && phase == 1) begin
                total++; if (a_rsp_rdata !== 16'h4444 || a_rsp_err !== 1'b0) begin
                    bad++; $display("FAIL rw_rdata: got %h e=%b want 4444/0", a_rsp_rdata, a_rsp_err); end
                $display("read addr1 rdata=%h", a_rsp_rdata);
            end
            take = a_req_ready && a_req_valid;
            step();
            if (take && phase == 0) begin
                phase = 1;
                a_req_write = wcmd.write; a_req_addr = wcmd.addr; a_req_wdata = wcmd.wdata;
            end else if (take && phase == 1) begin
                phase = 2;
                a_req_valid = 1'b0;
            end
        end
        a_req_valid = 1'b0;
        r_idx = -1; d_idx = -1;
        for (int k = 0; k < 8; k++) begin
            if (rd_seen[k] && r_idx < 0) r_idx = k;
            if (drv_seen[k] && r_idx >= 0 && d_idx < 0) d_idx = k;
        end
        gap_ok = (r_idx >= 0) && (d_idx > r_idx);
        if (gap_ok) begin
            for (int k = r_idx + 1; k < d_idx; k++) begin
                if (rd_seen[k] || wr_seen[k] || drv_seen[k]) gap_ok = 1'b0;
            end
        end
        total++; if (!gap_ok || d_idx - r_idx !== 3) begin
            bad++; $display("FAIL rw_gap: got read_cycle=%0d drive_cycle=%0d want drive 3 cycles after read with quiet gap", r_idx, d_idx); end
        mid();
        total++; if (p0_reg !== 16'h5A5A) begin bad++; $display("FAIL rw_port0: got %h want 5a5a", p0_reg); end
        $display("write addr0 data=%h after read, gap=%0d", p0_reg, d_idx - r_idx);
    endtask

    task automatic test_out_of_range();
        // In-range read first so that the error response must clear rdata.
        step();
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 2'd0;
        step();
        b_req_valid = 1'b0;
        step();
        mid();
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 16'hC3C3 || b_rsp_err !== 1'b0) begin
            bad++; $display("FAIL oor_pre: got v=%b d=%h e=%b want 1/c3c3/0", b_rsp_valid, b_rsp_rdata, b_rsp_err); end
        step();
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 2'd3;
        step();
        b_req_valid = 1'b0;
        mid();
        total++; if (b_port_read !== 3'b000 || b_port_write !== 3'b000 || dut_b.bus_drive !== 1'b0 || b_req_ready !== 1'b0) begin
            bad++; $display("FAIL oor_rd_strobe: got rd=%b wr=%b drv=%b rdy=%b want 000/000/0/0", b_port_read, b_port_write, dut_b.bus_drive, b_req_ready); end
        step();
        mid();
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1 || b_rsp_rdata !== 16'h0000 || b_req_ready !== 1'b0) begin
            bad++; $display("FAIL oor_rd_rsp: got v=%b e=%b d=%h rdy=%b want 1/1/0000/0", b_rsp_valid, b_rsp_err, b_rsp_rdata, b_req_ready); end
        step();
        mid();
        total++; if (b_req_ready !== 1'b1) begin bad++; $display("FAIL oor_turn_done: got %b want 1", b_req_ready); end
        $display("read addr3 (nports=3) err=%b rdata=%h", b_rsp_err, b_rsp_rdata);
        step();
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 2'd3; b_req_wdata = 16'hFFFF;
        step();
        b_req_valid = 1'b0;
        mid();
        total++; if (b_port_write !== 3'b000 || dut_b.bus_drive !== 1'b0) begin
            bad++; $display("FAIL oor_wr_strobe: got wr=%b drv=%b want 000/0", b_port_write, dut_b.bus_drive); end
        step();
        mid();
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1) begin
            bad++; $display("FAIL oor_wr_rsp: got v=%b e=%b want 1/1", b_rsp_valid, b_rsp_err); end
        $display("write addr3 (nports=3) err=%b", b_rsp_err);
        step();
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 2'd2; b_req_wdata = 16'h1234;
        step();
        b_req_valid = 1'b0;
        mid();
        total++; if (b_port_write !== 3'b100 || b_bus !== 16'h1234) begin
            bad++; $display("FAIL last_port_wr: got wr=%b bus=%h want 100/1234", b_port_write, b_bus); end
        step();
        mid();
        total++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin
            bad++; $display("FAIL last_port_rsp: got v=%b e=%b want 1/0", b_rsp_valid, b_rsp_err); end
        $display("write addr2 (nports=3) err=%b", b_rsp_err);
    endtask

    task automatic test_turnaround();
        int low;
        int rsp_at;
        low = 0;
        rsp_at = -1;
        step();
        c_req_valid = 1'b1; c_req_write = 1'b0; c_req_addr = 2'd1;
        mid();
        total++; if (c_req_ready !== 1'b1) begin bad++; $display("FAIL t3_ready: got %b want 1", c_req_ready); end
        step();
        c_req_valid = 1'b0;
        mid();
        while (!c_req_ready && low < 12) begin
            low++;
            if (c_rsp_valid && rsp_at < 0) rsp_at = low;
            mid();
        end
        total++; if (low !== 4) begin bad++; $display("FAIL t3_busy: got %0d cycles want 4", low); end
        total++; if (rsp_at !== 2) begin bad++; $display("FAIL t3_rsp_pos: got busy cycle %0d want 2", rsp_at); end
        total++; if (c_rsp_rdata !== 16'hBEEF || c_rsp_err !== 1'b0) begin
            bad++; $display("FAIL t3_rdata: got %h e=%b want beef/0", c_rsp_rdata, c_rsp_err); end
        $display("read addr1 (turnaround=3) busy=%0d rdata=%h", low, c_rsp_rdata);
    endtask

    task automatic test_contention();
        total++; if (cont_bad !== 0) begin bad++; $display("FAIL contention_total: got %0d violations want 0", cont_bad); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_turnaround();
        step();
        test_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
